// File: rtl/imem_loader.sv
// imem_loader: byte-stream boot loader for the instruction memory.
// Parses HDR, a 16-bit word count and little-endian words, then writes them.
module imem_loader #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] HDR    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [15:0]       r_cnt;
    logic [15:0]       r_widx;
    logic [1:0]        r_bidx;
    logic [23:0]       r_buf;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    logic              w_acc;
    logic              w_is_hdr;
    logic [15:0]       w_cnt_full;
    logic              w_last;
    logic              w_inrange;

    // Word index is kept at full count width so words past the memory
    // depth can be recognised and dropped instead of aliasing.
    assign in_ready   = !rst && (r_state != S_FIN);
    assign w_acc      = in_valid && in_ready;
    assign w_is_hdr   = (in_data == HDR);
    assign w_cnt_full = {in_data, r_cnt[7:0]};
    assign w_last     = (r_widx == (r_cnt - 16'd1));
    assign w_inrange  = ({1'b0, r_widx} < (17'd1 << ADDR_W));

    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign core_hold  = r_hold;
    assign done       = r_done;
    assign err        = r_err;

    // Frame parser next-state decision.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_acc && w_is_hdr) w_next = S_CNT_LO;
            S_CNT_LO: if (w_acc) w_next = S_CNT_HI;
            S_CNT_HI: begin
                if (w_acc) begin
                    w_next = (w_cnt_full == 16'd0) ? S_FIN : S_DATA;
                end
            end
            S_DATA: begin
                if (w_acc && (r_bidx == 2'd3) && w_last) w_next = S_FIN;
            end
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_buf   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_hold  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_FIN);
            r_we    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc && w_is_hdr) r_err <= 1'b0;
                end
                S_CNT_LO: begin
                    if (w_acc) r_cnt[7:0] <= in_data;
                end
                S_CNT_HI: begin
                    if (w_acc) begin
                        r_cnt[15:8] <= in_data;
                        r_widx      <= '0;
                        r_bidx      <= '0;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        if (r_bidx == 2'd3) begin
                            r_bidx  <= '0;
                            r_widx  <= r_widx + 16'd1;
                            r_waddr <= r_widx[ADDR_W-1:0];
                            r_wdata <= {in_data, r_buf};
                            if (w_inrange) r_we  <= 1'b1;
                            else           r_err <= 1'b1;
                        end else begin
                            r_bidx <= r_bidx + 2'd1;
                            unique case (r_bidx)
                                2'd0:    r_buf[7:0]   <= in_data;
                                2'd1:    r_buf[15:8]  <= in_data;
                                default: r_buf[23:16] <= in_data;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames against a frame-level model.
// Expected writes, done times, hold cycles and err come from the frame contents.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int         AW    = 2;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] HDR   = 8'hA5;

    typedef struct {
        longint      t;
        int          a;
        logic [31:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          err;

    int     checks = 0;
    int     errors = 0;
    wr_t    aq[$];
    wr_t    eq[$];
    longint adq[$];
    longint edq[$];
    int     hold_cnt = 0;
    int     hold_base = 0;
    longint exp_hold = 0;
    bit     exp_err = 1'b0;
    bit     pend = 1'b0;

    imem_loader #(.ADDR_W(AW), .HDR(HDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Observe outputs mid-cycle.
    always @(negedge clk) begin
        if (imem_we) aq.push_back('{longint'($time), int'(imem_waddr), imem_wdata});
        if (done) adq.push_back(longint'($time));
        if (core_hold) hold_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, output longint t, output int waits);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        t = longint'($time);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] junk[$], input logic [31:0] words[$],
                              input int gap);
        longint      t;
        longint      th;
        int          w;
        int          g;
        bit          first;
        logic [15:0] c16;
        logic [31:0] wv;
        first = 1'b1;
        c16   = 16'(words.size());
        foreach (junk[i]) begin
            send(junk[i], 0, t, w);
            if (first) chk("first_wait", w, pend ? 1 : 0);
            first = 1'b0;
        end
        g = 0;
        if (!first) g = (gap < 0) ? $urandom_range(0, 2) : gap;
        send(HDR, g, t, w);
        if (first) chk("first_wait", w, pend ? 1 : 0);
        th = t;
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
        send(c16[7:0], g, t, w);
        g = (gap < 0) ? $urandom_range(0, 2) : gap;
        send(c16[15:8], g, t, w);
        foreach (words[i]) begin
            wv = words[i];
            for (int k = 0; k < 4; k++) begin
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                send(wv[8*k +: 8], g, t, w);
            end
            if (i < DEPTH) eq.push_back('{t + 10, i, wv});
        end
        edq.push_back(t + 10);
        exp_hold += (t - th) / 10 + 1;
        exp_err   = (words.size() > DEPTH);
        pend      = 1'b1;
    endtask

    task automatic drain();
        wr_t    a;
        wr_t    e;
        longint x;
        longint y;
        repeat (4) @(negedge clk);
        chk("wr_count", aq.size(), eq.size());
        while (aq.size() > 0 && eq.size() > 0) begin
            a = aq.pop_front();
            e = eq.pop_front();
            chk("wr_addr", a.a, e.a);
            chk("wr_data", a.d, e.d);
            chk("wr_time", a.t, e.t);
        end
        aq.delete();
        eq.delete();
        chk("done_count", adq.size(), edq.size());
        while (adq.size() > 0 && edq.size() > 0) begin
            x = adq.pop_front();
            y = edq.pop_front();
            chk("done_time", x, y);
        end
        adq.delete();
        edq.delete();
        chk("hold_cycles", hold_cnt - hold_base, exp_hold);
        chk("err", err, exp_err);
        chk("idle_ready", in_ready, 1);
        chk("idle_hold", core_hold, 0);
        pend = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0]  jq[$];
        logic [31:0] wq[$];
        longint      t;
        int          w;
        int          nw;
        logic [7:0]  b;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        in_data  = HDR;
        @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_waddr", imem_waddr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_hold", core_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        hold_base = hold_cnt;

        // Two-word program, back-to-back bytes.
        jq.delete();
        wq.delete();
        wq.push_back(32'h00A00513);
        wq.push_back(32'h00B00593);
        send_frame(jq, wq, 0);
        drain();

        // Junk before header, zero-length frame.
        jq.push_back(8'h00);
        jq.push_back(8'hFF);
        wq.delete();
        send_frame(jq, wq, 0);
        drain();

        // Same program with three idle cycles between bytes.
        jq.delete();
        wq.push_back(32'h00A00513);
        wq.push_back(32'h00B00593);
        send_frame(jq, wq, 3);
        drain();

        // Abandon a partial frame with reset.
        send(HDR, 0, t, w);
        send(8'h01, 0, t, w);
        send(8'h00, 0, t, w);
        send(8'h11, 0, t, w);
        send(8'h22, 0, t, w);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_hold", core_hold, 0);
        chk("midrst_we", imem_we, 0);
        chk("midrst_waddr", imem_waddr, 0);
        chk("midrst_wdata", imem_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        hold_base = hold_cnt;
        exp_hold  = 0;
        exp_err   = 1'b0;
        chk("midrst_nowrite", aq.size(), 0);
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        send_frame(jq, wq, 0);
        drain();

        // Overflow past memory depth, HDR bytes inside data.
        wq.delete();
        wq.push_back(32'hA5A5A5A5);
        for (int i = 1; i < 5; i++) wq.push_back($urandom);
        send_frame(jq, wq, -1);
        drain();

        // Valid held across FIN, next header follows immediately.
        wq.delete();
        wq.push_back($urandom);
        send_frame(jq, wq, 0);
        wq.delete();
        wq.push_back($urandom);
        wq.push_back($urandom);
        send_frame(jq, wq, 0);
        drain();

        // Count with a non-zero high byte.
        wq.delete();
        for (int i = 0; i < 258; i++) wq.push_back($urandom);
        send_frame(jq, wq, 0);
        drain();

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            jq.delete();
            wq.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                if (b == HDR) b = b ^ 8'h01;
                jq.push_back(b);
            end
            nw = $urandom_range(0, 6);
            for (int i = 0; i < nw; i++) wq.push_back($urandom);
            send_frame(jq, wq, ($urandom_range(0, 1) == 0) ? 0 : -1);
            if (f == 19 || $urandom_range(0, 1) == 0) drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter HDR, default 8'hA5, meaning frame start byte.
REQ-003 SHALL have port: clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port: in_data  input  8  byte-stream data.
REQ-007 SHALL have port: in_ready  output  1  loader can accept a byte; a byte transfers on a posedge where in_valid & in_ready.
REQ-008 SHALL have port: imem_we  output  1  instruction-memory write enable.
REQ-009 SHALL have port: imem_waddr  output  ADDR_W  word write address.
REQ-010 SHALL have port: imem_wdata  output  32  word write data.
REQ-011 SHALL have port: core_hold  output  1  holds the processor core in reset while loading.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on load completion.
REQ-013 SHALL have port: err  output  1  sticky overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, CNT_LO, CNT_HI, DATA, FIN.
REQ-015 IDLE: accepted byte == HDR -> CNT_LO; any other byte is discarded, stay IDLE.
REQ-016 CNT_LO: accepted byte -> count[7:0], go CNT_HI.
REQ-017 CNT_HI: accepted byte -> count[15:8]; count == 0 -> FIN, else clear word address and byte index, go DATA.
REQ-018 DATA: bytes are assembled little-endian; byte index k (0..3) lands in wdata[8k+7:8k].
REQ-019 On the 4th accepted byte of a word, imem_we SHALL be 1 in the next cycle only, with imem_waddr = current word address and imem_wdata = assembled word.
REQ-020 Word address SHALL increment by 1 after each completed word; byte index wraps 3 -> 0.
REQ-021 After the word whose index is count-1 completes -> FIN.
REQ-022 Words with index >= 2^ADDR_W SHALL be consumed but not written (imem_we stays 0), and err SHALL be set; err stays set until reset or until the next HDR is accepted in IDLE.
REQ-023 FIN lasts exactly one cycle: done = 1, in_ready = 0, then -> IDLE.
REQ-024 in_ready SHALL be 1 in IDLE, CNT_LO, CNT_HI and DATA; 0 in FIN and during reset.
REQ-025 core_hold SHALL be 1 from the cycle after HDR is accepted through the FIN cycle inclusive; 0 in IDLE.
REQ-026 in_valid low SHALL stall all states except FIN without loss of partial-word or count state; there is no timeout.
REQ-027 A HDR byte received in CNT_LO, CNT_HI or DATA SHALL be treated as data or count, not as a restart.
REQ-028 imem_we, done and core_hold SHALL be registered outputs with no combinational path from in_valid or in_data.

Reset
REQ-029 rst high at a posedge SHALL force state IDLE, in_ready 0 in that cycle, imem_we 0, imem_waddr 0, imem_wdata 0, core_hold 0, done 0, err 0, count 0 and byte index 0.
REQ-030 Reset mid-frame SHALL abandon the frame; a partial word SHALL never be written, and the next frame SHALL start from IDLE.

Verification
REQ-031 Stream A5 02 00 13 05 A0 00 93 05 B0 00 shall produce writes addr 0 = 0x00A00513, then addr 1 = 0x00B00593, each one cycle after its 4th byte; done shall pulse once, and core_hold shall be high from the cycle after A5 through the done cycle.
REQ-032 Stream 00 FF A5 00 00 shall discard 00 and FF, produce no write, pulse done after the final 00, and leave err 0.
REQ-033 The REQ-031 stream with in_valid deasserted 3 cycles between every byte shall produce identical writes and data.
REQ-034 rst asserted after A5 01 00 11 22 shall produce no write and leave core_hold 0; the following frame A5 01 00 EF BE AD DE shall write addr 0 = 0xDEADBEEF.
REQ-035 With ADDR_W=2, a count of 5 shall write addresses 0..3; the 5th word shall not be written, err shall be 1, and done shall still pulse.
REQ-036 A held-high in_valid across FIN shall observe in_ready = 0 for exactly one cycle, and the byte held on in_data shall then be accepted in IDLE.
